// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: memory read port, instruction handshake to the hart,
// and the redirect request.
//   master : the fetch unit (drives mem_addr/mem_req and the instr_* outputs)
//   slave  : the surrounding hart/memory side
interface instr_fetch_unit_if #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned ILEN = 32
);
   logic [XLEN-1:0] mem_addr;
   logic            mem_req;
   logic            mem_grant;
   logic [XLEN-1:0] mem_rdata;
   logic            instr_valid;
   logic [ILEN-1:0] instr_bits;
   logic [XLEN-1:0] instr_pc;
   logic            instr_ready;
   logic            redirect_valid;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output mem_addr, mem_req, instr_valid, instr_bits, instr_pc,
      input  mem_grant, mem_rdata, instr_ready, redirect_valid, redirect_pc
   );

   modport slave (
      input  mem_addr, mem_req, instr_valid, instr_bits, instr_pc,
      output mem_grant, mem_rdata, instr_ready, redirect_valid, redirect_pc
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end. Issues fixed-latency word reads to memory,
// holding the address for READ_CYCLE_LATENCY+1 granted cycles, buffers the
// fetched {pc, bits} in a small FIFO and hands them to the hart via
// valid/ready. Supports PC redirects and yields the memory port on !mem_grant.
// Ports:
//   clock : clock, all state updates on posedge
//   reset : synchronous active-low reset
//   bus   : instr_fetch_unit_if.master (memory port, instr handshake, redirect)
module instr_fetch_unit #(
   parameter int unsigned    XLEN               = 32,
   parameter int unsigned    ILEN               = 32,
   parameter int unsigned    READ_CYCLE_LATENCY = 2,
   parameter int unsigned    QUEUE_DEPTH        = 2,
   parameter logic [XLEN-1:0] RESET_VECTOR      = '0
) (
   input logic                 clock,
   input logic                 reset,
   instr_fetch_unit_if.master  bus
);
   localparam int unsigned CNT_BITS = $clog2(READ_CYCLE_LATENCY + 1);
   localparam int unsigned CNT_W    = (CNT_BITS < 2) ? 2 : CNT_BITS;
   localparam int unsigned PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned OCC_W    = $clog2(QUEUE_DEPTH + 1);

   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(READ_CYCLE_LATENCY);
   localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(QUEUE_DEPTH);

   typedef enum logic {FETCH_IDLE, FETCH_READ} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
   logic [OCC_W-1:0]  count_q, count_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;

   logic [XLEN-1:0]   pc_mem   [QUEUE_DEPTH];
   logic [ILEN-1:0]   bits_mem [QUEUE_DEPTH];

   logic              head_valid;
   logic              pop;
   logic              capture;
   logic              push;
   logic [OCC_W-1:0]  occ_after;
   logic              slot_free;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Handshake and capture qualifiers; a redirect discards the same-cycle push.
   always_comb begin
      head_valid = (count_q != '0);
      pop        = head_valid && bus.instr_ready;
      capture    = (state_q == FETCH_READ) && bus.mem_grant && (cnt_q == '0);
      push       = capture && !bus.redirect_valid;
      occ_after  = count_q + OCC_W'(push) - OCC_W'(pop);
      slot_free  = (occ_after < OCC_MAX);
   end

   // Next-state logic for the fetch FSM, read counter, PC and FIFO pointers.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fetch_pc_d = fetch_pc_q;
      count_d    = occ_after;
      rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;

      case (state_q)
         FETCH_IDLE: begin
            if (slot_free) begin
               state_d = FETCH_READ;
               cnt_d   = LAT_CNT;
            end
         end
         FETCH_READ: begin
            if (!bus.mem_grant) begin
               // Port taken away: the read restarts its full latency.
               cnt_d = LAT_CNT;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               fetch_pc_d = fetch_pc_q + XLEN'(4);
               cnt_d      = LAT_CNT;
               if (!slot_free) state_d = FETCH_IDLE;
            end
         end
         default: state_d = FETCH_READ;
      endcase

      if (bus.redirect_valid) begin
         state_d    = FETCH_READ;
         cnt_d      = LAT_CNT;
         fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
         count_d    = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q    <= FETCH_READ;
         cnt_q      <= LAT_CNT;
         fetch_pc_q <= RESET_VECTOR;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fetch_pc_q <= fetch_pc_d;
         count_q    <= count_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // FIFO storage; contents are only meaningful under count_q.
   always_ff @(posedge clock) begin
      if (reset && push) begin
         pc_mem[wr_ptr_q]   <= fetch_pc_q;
         bits_mem[wr_ptr_q] <= ILEN'(bus.mem_rdata);
      end
   end

   // Outputs; request and valid are held low while reset is asserted.
   always_comb begin
      bus.mem_req     = reset && (state_q == FETCH_READ);
      bus.mem_addr    = fetch_pc_q;
      bus.instr_valid = reset && head_valid;
      bus.instr_bits  = bits_mem[rd_ptr_q];
      bus.instr_pc    = pc_mem[rd_ptr_q];
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a latency-checking memory model.
module tb_instr_fetch_unit;
   localparam int unsigned LAT = 2;
   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   instr_fetch_unit_if #(.XLEN(32), .ILEN(32)) bus ();

   instr_fetch_unit #(
      .XLEN(32), .ILEN(32), .READ_CYCLE_LATENCY(LAT),
      .QUEUE_DEPTH(2), .RESET_VECTOR(32'h0)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Memory returns addr^KEY only once the address has been held (requested
   // and granted) for LAT prior cycles; otherwise a poison word.
   int          held_cnt  = 0;
   logic [31:0] held_addr = 32'hFFFF_FFFF;
   always @(posedge clock) begin
      if (!reset || !bus.mem_req || !bus.mem_grant) begin
         held_cnt <= 0;
      end else if (bus.mem_addr == held_addr) begin
         held_cnt <= held_cnt + 1;
      end else begin
         held_addr <= bus.mem_addr;
         held_cnt  <= 1;
      end
   end
   assign bus.mem_rdata = (bus.mem_req && bus.mem_addr == held_addr && held_cnt >= int'(LAT))
                          ? (bus.mem_addr ^ KEY) : 32'hDEAD_BEEF;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Hold reset low for two edges; returns 1 time unit into cycle 0.
   task automatic start_run();
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;
      reset              = 1'b0;
      @(negedge clock);
      check_eq("rst_mem_req", 32'(bus.mem_req), 32'h0);
      check_eq("rst_valid", 32'(bus.instr_valid), 32'h0);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   // Cold-start timing with grant and ready held: valid at cycles 3,6,9...
   task automatic run_cold(input int ncyc);
      logic exp_v;
      bus.mem_grant   = 1'b1;
      bus.instr_ready = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clock);
         exp_v = (c % 3 == 0) && (c != 0);
         check_eq("cold_mem_req", 32'(bus.mem_req), 32'h1);
         check_eq("cold_mem_addr", bus.mem_addr, 32'((c / 3) * 4));
         check_eq("cold_valid", 32'(bus.instr_valid), 32'(exp_v));
         if (c % 3 == 0 && c != 0) begin
            check_eq("cold_pc", bus.instr_pc, 32'((c / 3 - 1) * 4));
            check_eq("cold_bits", bus.instr_bits, 32'((c / 3 - 1) * 4) ^ KEY);
         end
         step();
      end
   endtask

   initial begin
      bus.mem_grant      = 1'b1;
      bus.instr_ready    = 1'b1;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 32'h0;

      // Cold start
      start_run();
      run_cold(10);

      // Backpressure: fill both slots, then single pops reopen the fetch
      bus.instr_ready = 1'b0;
      start_run();
      for (int c = 0; c < 14; c++) begin
         bus.instr_ready = (c == 8 || c == 12 || c == 13);
         @(negedge clock);
         if (c == 6 || c == 7) begin
            check_eq("bp_idle_req", 32'(bus.mem_req), 32'h0);
            check_eq("bp_full_valid", 32'(bus.instr_valid), 32'h1);
            check_eq("bp_head_pc0", bus.instr_pc, 32'h0);
         end
         if (c == 8) check_eq("bp_pop_pc0", bus.instr_pc, 32'h0);
         if (c == 9) begin
            check_eq("bp_resume_req", 32'(bus.mem_req), 32'h1);
            check_eq("bp_resume_addr", bus.mem_addr, 32'h8);
            check_eq("bp_head_pc4", bus.instr_pc, 32'h4);
         end
         if (c == 12) begin
            check_eq("bp_refull_req", 32'(bus.mem_req), 32'h0);
            check_eq("bp_head_pc4b", bus.instr_pc, 32'h4);
         end
         if (c == 13) begin
            check_eq("bp_head_pc8", bus.instr_pc, 32'h8);
            check_eq("bp_bits8", bus.instr_bits, 32'hA5A5_0008);
         end
         step();
      end

      // Redirect mid-read (cnt == 1) to an unaligned target
      bus.instr_ready = 1'b1;
      start_run();
      for (int c = 0; c < 9; c++) begin
         bus.redirect_valid = (c == 4);
         bus.redirect_pc    = 32'h103;
         @(negedge clock);
         if (c == 3) check_eq("rd_pc0", bus.instr_pc, 32'h0);
         if (c == 5) begin
            check_eq("rd_req", 32'(bus.mem_req), 32'h1);
            check_eq("rd_addr", bus.mem_addr, 32'h100);
         end
         if (c >= 4 && c <= 7) check_eq("rd_gap_valid", 32'(bus.instr_valid), 32'h0);
         if (c == 8) begin
            check_eq("rd_tgt_valid", 32'(bus.instr_valid), 32'h1);
            check_eq("rd_tgt_pc", bus.instr_pc, 32'h100);
            check_eq("rd_tgt_bits", bus.instr_bits, 32'hA5A5_0100);
         end
         step();
      end
      bus.redirect_valid = 1'b0;

      // Redirect coincident with capture of 0x4 and a pop of 0x0
      start_run();
      for (int c = 0; c < 10; c++) begin
         bus.instr_ready    = (c >= 5);
         bus.redirect_valid = (c == 5);
         bus.redirect_pc    = 32'h202;
         @(negedge clock);
         if (c == 5) begin
            check_eq("rc_pop_valid", 32'(bus.instr_valid), 32'h1);
            check_eq("rc_pop_pc", bus.instr_pc, 32'h0);
         end
         if (c == 6) check_eq("rc_addr", bus.mem_addr, 32'h200);
         if (c >= 6 && c <= 8) check_eq("rc_empty", 32'(bus.instr_valid), 32'h0);
         if (c == 9) begin
            check_eq("rc_tgt_valid", 32'(bus.instr_valid), 32'h1);
            check_eq("rc_tgt_pc", bus.instr_pc, 32'h200);
            check_eq("rc_tgt_bits", bus.instr_bits, 32'hA5A5_0200);
         end
         step();
      end
      bus.redirect_valid = 1'b0;

      // Grant dropped in cycles 1-2
      bus.instr_ready = 1'b1;
      start_run();
      for (int c = 0; c < 7; c++) begin
         bus.mem_grant = !(c == 1 || c == 2);
         @(negedge clock);
         if (c <= 5) begin
            check_eq("gd_req", 32'(bus.mem_req), 32'h1);
            check_eq("gd_addr", bus.mem_addr, 32'h0);
            check_eq("gd_valid", 32'(bus.instr_valid), 32'h0);
         end else begin
            check_eq("gd_late_valid", 32'(bus.instr_valid), 32'h1);
            check_eq("gd_late_pc", bus.instr_pc, 32'h0);
            check_eq("gd_late_bits", bus.instr_bits, KEY);
         end
         step();
      end
      bus.mem_grant = 1'b1;

      // Reset mid-operation: one entry buffered, read at its capture cycle
      bus.instr_ready = 1'b0;
      start_run();
      for (int c = 0; c < 6; c++) begin
         if (c == 5) reset = 1'b0;
         @(negedge clock);
         if (c == 3) check_eq("mr_buffered", 32'(bus.instr_valid), 32'h1);
         if (c == 5) begin
            check_eq("mr_valid_gated", 32'(bus.instr_valid), 32'h0);
            check_eq("mr_req_gated", 32'(bus.mem_req), 32'h0);
         end
         step();
      end
      reset = 1'b1;
      run_cold(7);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
